// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode constants, fetch FSM states and the
// IF/ID payload carried through the fetch stage and its skid buffer.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE  = 6'b000000;
  localparam logic [5:0]  OP_LW     = 6'b100011;
  localparam logic [5:0]  OP_SW     = 6'b101011;
  localparam logic [5:0]  OP_ADDI   = 6'b001000;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory req/ack port. The fetch stage is the master; the memory
// (or the bench) is the slave.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry holding register for a fetched word that IF/ID could not take.
// clr beats load, load beats drain (a load+drain pair refills the entry).
module if_skid_buf
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load,
  input  logic  drain,
  input  ifid_t din,
  output logic  vld,
  output ifid_t dout
);

  logic  vld_d, vld_q;
  ifid_t data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clr) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d  = 1'b1;
      data_d = din;
    end else if (drain) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign dout = data_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// feeds decode through IF/ID plus a one-entry skid, and honours PCSrc redirects.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  input  logic        stall,
  if_stage_if.master  imem,
  output logic        valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  if_state_e   state_d, state_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] drop_addr_d, drop_addr_q;
  logic        drop_d, drop_q;
  logic        valid_d, valid_q;
  logic        fault_d, fault_q;
  logic [15:0] cnt_d, cnt_q;
  ifid_t       ifid_d, ifid_q;

  logic        req, ack, skid_nxt;
  logic        sk_clr, sk_load, sk_drain, skid_vld;
  ifid_t       skid_dout, word;

  // No request is driven in a reset cycle, so an ack there is never accepted.
  assign req = (state_q == S_REQ) && !rst;
  assign ack = req && imem.imem_ack;
  assign word = '{instr: imem.imem_rdata, pc_plus4: pc_q + 32'd4};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    drop_addr_d = drop_addr_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    ifid_d      = ifid_q;
    sk_clr      = 1'b0;
    sk_load     = 1'b0;
    sk_drain    = 1'b0;
    skid_nxt    = skid_vld;
    if (state_q != S_FAULT) begin
      if (req && !imem.imem_ack) cnt_d = cnt_q + 16'd1;
      else if (ack)              cnt_d = '0;
      if (pcsrc) begin
        pc_d    = align_pc(branch_target);
        valid_d = 1'b0;
        sk_clr  = 1'b1;
        state_d = S_REQ;
        // An outstanding fetch must still finish at its old address.
        drop_d  = req && !imem.imem_ack;
        if (!drop_q) drop_addr_d = pc_q;
      end else begin
        if (!stall) begin
          if (skid_vld) begin
            valid_d  = 1'b1;
            ifid_d   = skid_dout;
            sk_drain = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        if (ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            pc_d = pc_q + 32'd4;
            // Skid holds the older word, so a new word only bypasses it when empty.
            if ((!valid_q || !stall) && !skid_vld) begin
              valid_d = 1'b1;
              ifid_d  = word;
            end else begin
              sk_load = 1'b1;
            end
          end
        end
        skid_nxt = sk_load || (skid_vld && !sk_drain);
        state_d  = skid_nxt ? S_HOLD : S_REQ;
      end
      if (TIMEOUT != 0 && req && !imem.imem_ack && (cnt_q + 16'd1) == 16'(TIMEOUT)) begin
        fault_d = 1'b1;
        valid_d = 1'b0;
        state_d = S_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      drop_addr_q <= '0;
      valid_q     <= 1'b0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      ifid_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      drop_addr_q <= drop_addr_d;
      valid_q     <= valid_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      ifid_q      <= ifid_d;
    end
  end

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (sk_clr),
    .load  (sk_load),
    .drain (sk_drain),
    .din   (word),
    .vld   (skid_vld),
    .dout  (skid_dout)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = drop_q ? drop_addr_q : pc_q;
  assign valid          = valid_q;
  assign instr          = valid_q ? ifid_q.instr : NOP_INSTR;
  assign opcode         = valid_q ? ifid_q.instr[31:26] : OP_RTYPE;
  assign pc_plus4       = ifid_q.pc_plus4;
  assign fault          = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, zero-wait and wait-state fetch, stall/skid,
// redirects (outstanding and same-cycle), PC wrap and memory timeout.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, pcsrc, stall;
  logic [31:0] branch_target;
  logic        valid, fault;
  logic [31:0] instr, pc_plus4;
  logic [5:0]  opcode;
  int          total = 0, bad = 0, wcnt = 0;

  if_stage_if imem();

  if_stage #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .imem(imem), .valid(valid), .instr(instr), .opcode(opcode), .pc_plus4(pc_plus4),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h8C01_0004;
      32'h4:   return 32'h0000_0000;
      32'h8:   return 32'hAC02_0008;
      32'hC:   return 32'h2003_0001;
      default: return 32'h2000_0000 | a;
    endcase
  endfunction

  // Memory responds after w wait cycles per request.
  task automatic mem_drive(input int w);
    if (imem.imem_req) begin
      if (wcnt >= w) begin
        imem.imem_ack = 1'b1; imem.imem_rdata = memword(imem.imem_addr); wcnt = 0;
      end else begin
        imem.imem_ack = 1'b0; imem.imem_rdata = 32'hDEAD_BEEF; wcnt++;
      end
    end else begin
      imem.imem_ack = 1'b0; wcnt = 0;
    end
  endtask

  task automatic cyc(input int w);
    #1; mem_drive(w); @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; pcsrc = 1'b0; stall = 1'b0; branch_target = '0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0; wcnt = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; pcsrc = 1'b0; stall = 1'b0; branch_target = '0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h8C01_0004;
    @(posedge clk); #1;
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem.imem_req); end
    @(posedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
    rst = 1'b0; imem.imem_ack = 1'b0; #1;
    total++; if (imem.imem_req !== 1'b1) begin bad++; $display("FAIL post_rst_req got=%b exp=1", imem.imem_req); end
    total++; if (imem.imem_addr !== 32'h0) begin bad++; $display("FAIL post_rst_addr got=%h exp=0", imem.imem_addr); end
    total++; if (instr !== 32'h0 || opcode !== 6'h0) begin bad++; $display("FAIL rst_instr got=%h/%h exp=0", instr, opcode); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", pc_plus4); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] ea [3] = '{32'h0, 32'h4, 32'h8};
    logic [5:0]  eo [3] = '{6'b100011, 6'b000000, 6'b101011};
    logic [31:0] ep [3] = '{32'h4, 32'h8, 32'hC};
    do_reset();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL zw_pre_valid got=%b exp=0", valid); end
    for (int i = 0; i < 3; i++) begin
      total++; if (imem.imem_addr !== ea[i]) begin bad++; $display("FAIL zw_addr%0d got=%h exp=%h", i, imem.imem_addr, ea[i]); end
      cyc(0);
      total++; if (valid !== 1'b1 || opcode !== eo[i] || pc_plus4 !== ep[i])
        begin bad++; $display("FAIL zw_out%0d got=%b/%b/%h exp=1/%b/%h", i, valid, opcode, pc_plus4, eo[i], ep[i]); end
    end
    total++; if (instr !== 32'hAC02_0008) begin bad++; $display("FAIL zw_instr got=%h exp=ac020008", instr); end
  endtask

  task automatic test_wait;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ea;
      logic        ev;
      ea = (k < 4) ? 32'h0 : 32'h4;
      ev = (k == 3 || k == 7);
      total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== ea)
        begin bad++; $display("FAIL wait_addr%0d got=%b/%h exp=1/%h", k, imem.imem_req, imem.imem_addr, ea); end
      cyc(3);
      total++; if (valid !== ev) begin bad++; $display("FAIL wait_valid%0d got=%b exp=%b", k, valid, ev); end
    end
    total++; if (fault !== 1'b0 || pc_plus4 !== 32'h8) begin bad++; $display("FAIL wait_end got=%b/%h exp=0/8", fault, pc_plus4); end
  endtask

  task automatic test_stall;
    do_reset();
    cyc(0);
    total++; if (valid !== 1'b1 || instr !== 32'h8C01_0004) begin bad++; $display("FAIL st_first got=%b/%h exp=1/8c010004", valid, instr); end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0);
      total++; if (imem.imem_req !== 1'b0 || valid !== 1'b1 || instr !== 32'h8C01_0004 || pc_plus4 !== 32'h4)
        begin bad++; $display("FAIL st_hold%0d got=%b/%b/%h/%h exp=0/1/8c010004/4", k, imem.imem_req, valid, instr, pc_plus4); end
    end
    stall = 1'b0;
    cyc(0);
    total++; if (valid !== 1'b1 || instr !== 32'h0 || pc_plus4 !== 32'h8)
      begin bad++; $display("FAIL st_drain got=%b/%h/%h exp=1/0/8", valid, instr, pc_plus4); end
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8)
      begin bad++; $display("FAIL st_resume got=%b/%h exp=1/8", imem.imem_req, imem.imem_addr); end
    cyc(0);
    total++; if (instr !== 32'hAC02_0008 || pc_plus4 !== 32'hC) begin bad++; $display("FAIL st_next got=%h/%h exp=ac020008/c", instr, pc_plus4); end
    cyc(0);
    total++; if (opcode !== 6'b001000 || pc_plus4 !== 32'h10) begin bad++; $display("FAIL st_last got=%b/%h exp=001000/10", opcode, pc_plus4); end
  endtask

  task automatic test_redirect;
    do_reset();
    cyc(0); cyc(0);
    total++; if (imem.imem_addr !== 32'h8 || valid !== 1'b1) begin bad++; $display("FAIL rd_setup got=%h/%b exp=8/1", imem.imem_addr, valid); end
    pcsrc = 1'b1; branch_target = 32'h0000_0103;
    cyc(2);
    pcsrc = 1'b0;
    total++; if (valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h8)
      begin bad++; $display("FAIL rd_old_addr got=%b/%b/%h exp=0/1/8", valid, imem.imem_req, imem.imem_addr); end
    cyc(2);
    total++; if (valid !== 1'b0 || imem.imem_addr !== 32'h8) begin bad++; $display("FAIL rd_wait got=%b/%h exp=0/8", valid, imem.imem_addr); end
    cyc(2);
    total++; if (valid !== 1'b0 || imem.imem_addr !== 32'h100) begin bad++; $display("FAIL rd_target got=%b/%h exp=0/100", valid, imem.imem_addr); end
    cyc(0);
    total++; if (valid !== 1'b1 || instr !== 32'h2000_0100 || pc_plus4 !== 32'h104)
      begin bad++; $display("FAIL rd_land got=%b/%h/%h exp=1/20000100/104", valid, instr, pc_plus4); end
  endtask

  task automatic test_pcsrc_ack;
    do_reset();
    cyc(0);
    pcsrc = 1'b1; branch_target = 32'h0000_0200;
    cyc(0);
    pcsrc = 1'b0;
    total++; if (valid !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h200)
      begin bad++; $display("FAIL pa_redirect got=%b/%b/%h exp=0/1/200", valid, imem.imem_req, imem.imem_addr); end
    cyc(0);
    total++; if (valid !== 1'b1 || instr !== 32'h2000_0200 || pc_plus4 !== 32'h204)
      begin bad++; $display("FAIL pa_land got=%b/%h/%h exp=1/20000200/204", valid, instr, pc_plus4); end
  endtask

  task automatic test_wrap;
    do_reset();
    pcsrc = 1'b1; branch_target = 32'hFFFF_FFFF;
    cyc(0);
    pcsrc = 1'b0;
    total++; if (imem.imem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin bad++; $display("FAIL wrap_addr got=%h/%b exp=fffffffc/0", imem.imem_addr, valid); end
    cyc(0);
    total++; if (valid !== 1'b1 || pc_plus4 !== 32'h0 || imem.imem_addr !== 32'h0)
      begin bad++; $display("FAIL wrap_pc got=%b/%h/%h exp=1/0/0", valid, pc_plus4, imem.imem_addr); end
  endtask

  task automatic test_timeout;
    do_reset();
    cyc(0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1000);
      total++; if (fault !== 1'b0 || imem.imem_req !== 1'b1) begin bad++; $display("FAIL to_early%0d got=%b/%b exp=0/1", k, fault, imem.imem_req); end
    end
    cyc(1000);
    total++; if (fault !== 1'b1 || imem.imem_req !== 1'b0 || valid !== 1'b0)
      begin bad++; $display("FAIL to_fault got=%b/%b/%b exp=1/0/0", fault, imem.imem_req, valid); end
    pcsrc = 1'b1; branch_target = 32'h40;
    cyc(1000);
    pcsrc = 1'b0;
    cyc(1000);
    total++; if (fault !== 1'b1 || imem.imem_req !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b exp=1/0", fault, imem.imem_req); end
    do_reset();
    total++; if (fault !== 1'b0 || imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0)
      begin bad++; $display("FAIL to_clear got=%b/%b/%h exp=0/1/0", fault, imem.imem_req, imem.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait();
    test_stall();
    test_redirect();
    test_pcsrc_ack();
    test_wrap();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
